kianv_clint: RTL and testbench

//  Core-local interruptor on the core's native memory bus, downstream of the rv32ima multicycle core.

---
 rtl/kianv_clint_pkg.sv | 53 +++++
 rtl/kianv_clint_if.sv | 21 ++
 rtl/kianv_clint_timer.sv | 46 ++++
 rtl/kianv_clint.sv | 135 +++++++++++++
 tb/tb_kianv_clint.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/kianv_clint_pkg.sv
// Shared definitions for the core-local interruptor: register offsets,
// bus FSM states, register decode and byte-strobe merge helpers.
package kianv_clint_pkg;

    localparam logic [15:0] CLINT_MSIP        = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_LO = 16'h4000;
    localparam logic [15:0] CLINT_MTIMECMP_HI = 16'h4004;
    localparam logic [15:0] CLINT_MTIME_LO    = 16'hBFF8;
    localparam logic [15:0] CLINT_MTIME_HI    = 16'hBFFC;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } clint_state_t;

    typedef enum logic [2:0] {
        REG_NONE     = 3'd0,
        REG_MSIP     = 3'd1,
        REG_CMP_LO   = 3'd2,
        REG_CMP_HI   = 3'd3,
        REG_MTIME_LO = 3'd4,
        REG_MTIME_HI = 3'd5
    } clint_reg_t;

    // Misaligned offsets fall through to REG_NONE so they fault like holes.
    function automatic clint_reg_t decode_offset(input logic [15:0] off);
        clint_reg_t r;
        r = REG_NONE;
        if (off[1:0] == 2'b00) begin
            case (off)
                CLINT_MSIP:        r = REG_MSIP;
                CLINT_MTIMECMP_LO: r = REG_CMP_LO;
                CLINT_MTIMECMP_HI: r = REG_CMP_HI;
                CLINT_MTIME_LO:    r = REG_MTIME_LO;
                CLINT_MTIME_HI:    r = REG_MTIME_HI;
                default:           r = REG_NONE;
            endcase
        end
        return r;
    endfunction

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wstrb);
        logic [31:0] r;
        r = old_val;
        for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) r[8*b +: 8] = wdata[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/kianv_clint_if.sv
// Native memory-bus port of the core-local interruptor.
interface kianv_clint_if;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        access_fault;
    logic        sel;

    modport master (
        output mem_valid, mem_addr, mem_wstrb, mem_wdata,
        input  mem_rdata, mem_ready, access_fault, sel
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wstrb, mem_wdata,
        output mem_rdata, mem_ready, access_fault, sel
    );
endinterface

// File: rtl/kianv_clint_timer.sv
// Prescaled 64-bit mtime counter; a bus write to either half overrides the
// increment for that cycle and never carries across halves.
module kianv_clint_timer
    import kianv_clint_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  wr_lo_strb,
    input  logic [3:0]  wr_hi_strb,
    input  logic [31:0] wdata,
    output logic [63:0] mtime
);

    localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);

    logic [15:0] prescaler;
    logic        tick;
    logic        bus_write;

    assign tick      = (prescaler == PRESC_LAST);
    assign bus_write = (|wr_lo_strb) || (|wr_hi_strb);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= 16'd0;
        end else if (tick) begin
            prescaler <= 16'd0;
        end else begin
            prescaler <= prescaler + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime <= 64'd0;
        end else if (bus_write) begin
            mtime <= {apply_wstrb(mtime[63:32], wdata, wr_hi_strb),
                      apply_wstrb(mtime[31:0],  wdata, wr_lo_strb)};
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

endmodule

// File: rtl/kianv_clint.sv
// Core-local interruptor: bus FSM, register decode, mtimecmp/msip and the
// registered MTIP (IRQ7) / MSIP (IRQ3) outputs.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting; an in-window request is executed on this edge
// ST_ACK  | mem_ready (and access_fault if unmapped) for one cycle
module kianv_clint
    import kianv_clint_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic          clk,
    input  logic          rst,
    kianv_clint_if.slave  bus,
    output logic          IRQ3,
    output logic          IRQ7
);

    clint_state_t state_q, state_d;
    clint_reg_t   reg_sel;

    logic        sel;
    logic        accept;
    logic        is_write;
    logic [31:0] rd_mux;
    logic [31:0] rdata_q;
    logic        fault_q;
    logic        msip;
    logic [63:0] mtimecmp;
    logic [63:0] mtime;
    logic [3:0]  mtime_lo_strb;
    logic [3:0]  mtime_hi_strb;

    assign sel      = bus.mem_valid && (bus.mem_addr[31:16] == BASE_ADDR[31:16]);
    assign reg_sel  = decode_offset(bus.mem_addr[15:0]);
    assign is_write = |bus.mem_wstrb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // mem_valid is not looked at in ST_ACK, so a held request is serviced once.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sel) begin
                    accept  = 1'b1;
                    state_d = ST_ACK;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mtime_lo_strb = 4'b0000;
        mtime_hi_strb = 4'b0000;
        if (accept && reg_sel == REG_MTIME_LO) mtime_lo_strb = bus.mem_wstrb;
        if (accept && reg_sel == REG_MTIME_HI) mtime_hi_strb = bus.mem_wstrb;
    end

    kianv_clint_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .wr_lo_strb (mtime_lo_strb),
        .wr_hi_strb (mtime_hi_strb),
        .wdata      (bus.mem_wdata),
        .mtime      (mtime)
    );

    // mtime is sampled before this cycle's increment lands.
    always_comb begin
        rd_mux = 32'h0;
        case (reg_sel)
            REG_MSIP:     rd_mux = {31'h0, msip};
            REG_CMP_LO:   rd_mux = mtimecmp[31:0];
            REG_CMP_HI:   rd_mux = mtimecmp[63:32];
            REG_MTIME_LO: rd_mux = mtime[31:0];
            REG_MTIME_HI: rd_mux = mtime[63:32];
            default:      rd_mux = 32'h0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= 32'h0;
            fault_q <= 1'b0;
        end else if (accept) begin
            rdata_q <= is_write ? 32'h0 : rd_mux;
            fault_q <= (reg_sel == REG_NONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msip     <= 1'b0;
            mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
        end else if (accept) begin
            case (reg_sel)
                REG_MSIP: begin
                    if (bus.mem_wstrb[0]) msip <= bus.mem_wdata[0];
                end
                REG_CMP_LO:
                    mtimecmp[31:0]  <= apply_wstrb(mtimecmp[31:0],  bus.mem_wdata, bus.mem_wstrb);
                REG_CMP_HI:
                    mtimecmp[63:32] <= apply_wstrb(mtimecmp[63:32], bus.mem_wdata, bus.mem_wstrb);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            IRQ3 <= 1'b0;
            IRQ7 <= 1'b0;
        end else begin
            IRQ3 <= msip;
            IRQ7 <= (mtime >= mtimecmp);
        end
    end

    assign bus.sel          = sel;
    assign bus.mem_ready    = (state_q == ST_ACK);
    assign bus.access_fault = (state_q == ST_ACK) && fault_q;
    assign bus.mem_rdata    = rdata_q;

endmodule

// File: tb/tb_kianv_clint.sv
// Directed bench for kianv_clint: one instance ticking every cycle, one
// with a divide-by-4 prescaler, sharing clock and reset.
module tb_kianv_clint;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic irq3_a, irq7_a, irq3_b, irq7_b;
    int   vectors = 0;
    int   errors  = 0;
    int   cyc;

    kianv_clint_if bus_a ();
    kianv_clint_if bus_b ();

    kianv_clint #(.BASE_ADDR(32'h0200_0000), .TICK_DIV(1)) dut_a (
        .clk (clk), .rst (rst), .bus (bus_a), .IRQ3 (irq3_a), .IRQ7 (irq7_a));

    kianv_clint #(.BASE_ADDR(32'h0200_0000), .TICK_DIV(4)) dut_b (
        .clk (clk), .rst (rst), .bus (bus_b), .IRQ3 (irq3_b), .IRQ7 (irq7_b));

    always #5 clk = ~clk;

    // Edge index since reset release: after edge En, cyc == n.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic bus_xfer(input bit which, input logic [31:0] addr,
                            input logic [3:0] wstrb, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic fault,
                            output logic ready, output int acc);
        @(negedge clk);
        bus_a.mem_addr  = addr;  bus_b.mem_addr  = addr;
        bus_a.mem_wstrb = wstrb; bus_b.mem_wstrb = wstrb;
        bus_a.mem_wdata = wdata; bus_b.mem_wdata = wdata;
        bus_a.mem_valid = !which;
        bus_b.mem_valid = which;
        @(posedge clk);
        #1;
        ready = which ? bus_b.mem_ready    : bus_a.mem_ready;
        fault = which ? bus_b.access_fault : bus_a.access_fault;
        rdata = which ? bus_b.mem_rdata    : bus_a.mem_rdata;
        acc   = cyc;
        @(negedge clk);
        bus_a.mem_valid = 1'b0; bus_b.mem_valid = 1'b0;
        bus_a.mem_wstrb = 4'h0; bus_b.mem_wstrb = 4'h0;
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic flt, rdy; int n;
        #1;
        vectors++;
        if ({irq3_a, irq7_a, irq3_b, irq7_b} !== 4'b0000) begin
            errors++; $display("FAIL reset_irq: got %b want 0000", {irq3_a, irq7_a, irq3_b, irq7_b});
        end
        vectors++;
        if ({bus_a.mem_ready, bus_a.access_fault, bus_b.mem_ready} !== 3'b000 || bus_a.mem_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_bus: ready/fault %b rdata %h want 000/0",
                               {bus_a.mem_ready, bus_a.access_fault, bus_b.mem_ready}, bus_a.mem_rdata);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        bus_a.mem_addr = 32'h0200_4004; bus_a.mem_wstrb = 4'h0; bus_a.mem_valid = 1'b1;
        #1;
        vectors++;
        if (bus_a.mem_ready !== 1'b0 || bus_a.sel !== 1'b1) begin
            errors++; $display("FAIL pre_edge: ready %b sel %b want 0 1", bus_a.mem_ready, bus_a.sel);
        end
        @(posedge clk); #1;
        vectors++;
        if (bus_a.mem_ready !== 1'b1 || bus_a.mem_rdata !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL cmp_hi_reset: ready %b rdata %h want 1 ffffffff", bus_a.mem_ready, bus_a.mem_rdata);
        end
        @(negedge clk); bus_a.mem_valid = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (bus_a.mem_ready !== 1'b0) begin
            errors++; $display("FAIL ready_pulse: got %b want 0", bus_a.mem_ready);
        end
        bus_xfer(0, 32'h0200_4000, 4'h0, 32'h0, rd, flt, rdy, n);
        vectors++;
        if (rdy !== 1'b1 || flt !== 1'b0 || rd !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL cmp_lo_reset: ready %b fault %b rdata %h want 1 0 ffffffff", rdy, flt, rd);
        end
        bus_xfer(0, 32'h0200_BFF8, 4'h0, 32'h0, rd, flt, rdy, n);
        vectors++;
        if (rd !== 32'(n - 1)) begin
            errors++; $display("FAIL mtime_from_reset: got %h want %h", rd, 32'(n - 1));
        end
    endtask

    task automatic test_prescaler();
        logic [31:0] rd; logic flt, rdy; int n; int guard;
        guard = 0;
        while (cyc < 40 && guard < 200) begin
            @(posedge clk); guard++;
        end
        for (int i = 0; i < 4; i++) begin
            bus_xfer(1, 32'h0200_BFF8, 4'h0, 32'h0, rd, flt, rdy, n);
            vectors++;
            if (rdy !== 1'b1 || rd !== 32'((n - 1) / 4)) begin
                errors++; $display("FAIL div4_mtime[%0d]: ready %b got %0d want %0d", i, rdy, rd, (n - 1) / 4);
            end
        end
    endtask

    task automatic test_mtime_write();
        logic [31:0] rd; logic flt, rdy; int n;
        bus_xfer(0, 32'h0200_BFFC, 4'hF, 32'h0, rd, flt, rdy, n);
        bus_xfer(0, 32'h0200_BFF8, 4'hF, 32'hFFFF_FFFF, rd, flt, rdy, n);
        bus_xfer(0, 32'h0200_BFFC, 4'h0, 32'h0, rd, flt, rdy, n);
        vectors++;
        if (rd !== 32'h1) begin
            errors++; $display("FAIL carry_hi: got %h want 00000001", rd);
        end
        bus_xfer(0, 32'h0200_BFF8, 4'h0, 32'h0, rd, flt, rdy, n);
        vectors++;
        if (rd !== 32'h2) begin
            errors++; $display("FAIL carry_lo: got %h want 00000002", rd);
        end
        bus_xfer(0, 32'h0200_BFF8, 4'hF, 32'h1234_5678, rd, flt, rdy, n);
        bus_xfer(0, 32'h0200_BFF8, 4'h1, 32'h0000_00AB, rd, flt, rdy, n);
        bus_xfer(0, 32'h0200_BFF8, 4'h0, 32'h0, rd, flt, rdy, n);
        vectors++;
        if (rd !== 32'h1234_56AC) begin
            errors++; $display("FAIL byte_write_lo: got %h want 123456ac", rd);
        end
        bus_xfer(0, 32'h0200_BFFC, 4'h0, 32'h0, rd, flt, rdy, n);
        vectors++;
        if (rd !== 32'h1) begin
            errors++; $display("FAIL byte_write_hi: got %h want 00000001", rd);
        end
    endtask

    task automatic test_mtip();
        logic [31:0] rd; logic flt, rdy; int n;
        bus_xfer(0, 32'h0200_BFFC, 4'hF, 32'h0, rd, flt, rdy, n);
        bus_xfer(0, 32'h0200_BFF8, 4'hF, 32'h0, rd, flt, rdy, n);
        bus_xfer(0, 32'h0200_4004, 4'hF, 32'h0, rd, flt, rdy, n);
        bus_xfer(0, 32'h0200_4000, 4'hF, 32'h9, rd, flt, rdy, n);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            vectors++;
            if (irq7_a !== (k == 6)) begin
                errors++; $display("FAIL mtip_rise[%0d]: got %b want %b", k, irq7_a, k == 6);
            end
        end
        bus_xfer(0, 32'h0200_4004, 4'hF, 32'hFFFF_FFFF, rd, flt, rdy, n);
        vectors++;
        if (irq7_a !== 1'b1) begin
            errors++; $display("FAIL mtip_in_ack: got %b want 1", irq7_a);
        end
        @(posedge clk); #1;
        vectors++;
        if (irq7_a !== 1'b0) begin
            errors++; $display("FAIL mtip_clear: got %b want 0", irq7_a);
        end
    endtask

    task automatic test_msip();
        logic [31:0] rd; logic flt, rdy; int n;
        bus_xfer(0, 32'h0200_0000, 4'hF, 32'h3, rd, flt, rdy, n);
        vectors++;
        if (irq3_a !== 1'b0) begin
            errors++; $display("FAIL msip_stage: got %b want 0", irq3_a);
        end
        @(posedge clk); #1;
        vectors++;
        if (irq3_a !== 1'b1) begin
            errors++; $display("FAIL msip_set: got %b want 1", irq3_a);
        end
        bus_xfer(0, 32'h0200_0000, 4'h0, 32'h0, rd, flt, rdy, n);
        vectors++;
        if (rd !== 32'h1 || flt !== 1'b0) begin
            errors++; $display("FAIL msip_read: rdata %h fault %b want 00000001 0", rd, flt);
        end
        bus_xfer(0, 32'h0200_0000, 4'hF, 32'h0, rd, flt, rdy, n);
        @(posedge clk); #1;
        vectors++;
        if (irq3_a !== 1'b0) begin
            errors++; $display("FAIL msip_clear: got %b want 0", irq3_a);
        end
    endtask

    task automatic test_fault();
        logic [31:0] rd; logic flt, rdy; int n;
        bus_xfer(0, 32'h0200_0008, 4'h0, 32'h0, rd, flt, rdy, n);
        vectors++;
        if (rdy !== 1'b1 || flt !== 1'b1 || rd !== 32'h0) begin
            errors++; $display("FAIL hole_read: ready %b fault %b rdata %h want 1 1 0", rdy, flt, rd);
        end
        bus_xfer(0, 32'h0200_4002, 4'h0, 32'h0, rd, flt, rdy, n);
        vectors++;
        if (flt !== 1'b1 || rd !== 32'h0) begin
            errors++; $display("FAIL misaligned_read: fault %b rdata %h want 1 0", flt, rd);
        end
        bus_xfer(0, 32'h0200_4001, 4'hF, 32'h0, rd, flt, rdy, n);
        bus_xfer(0, 32'h0200_4008, 4'hF, 32'h0, rd, flt, rdy, n);
        bus_xfer(0, 32'h0200_4000, 4'h0, 32'h0, rd, flt, rdy, n);
        vectors++;
        if (rd !== 32'h9 || flt !== 1'b0) begin
            errors++; $display("FAIL dropped_write: rdata %h fault %b want 00000009 0", rd, flt);
        end
        @(negedge clk);
        bus_a.mem_addr = 32'h0300_0000; bus_a.mem_wstrb = 4'h0; bus_a.mem_valid = 1'b1;
        #1;
        vectors++;
        if (bus_a.sel !== 1'b0) begin
            errors++; $display("FAIL out_of_window_sel: got %b want 0", bus_a.sel);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            vectors++;
            if (bus_a.mem_ready !== 1'b0) begin
                errors++; $display("FAIL out_of_window_ready[%0d]: got %b want 0", k, bus_a.mem_ready);
            end
        end
        @(negedge clk); bus_a.mem_valid = 1'b0;
    endtask

    task automatic test_reset_in_ack();
        logic [31:0] rd; logic flt, rdy; int n;
        bus_xfer(0, 32'h0200_4000, 4'hF, 32'h0000_0055, rd, flt, rdy, n);
        @(negedge clk);
        bus_a.mem_addr = 32'h0200_0000; bus_a.mem_wstrb = 4'hF;
        bus_a.mem_wdata = 32'h1; bus_a.mem_valid = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (bus_a.mem_ready !== 1'b1) begin
            errors++; $display("FAIL ack_before_reset: got %b want 1", bus_a.mem_ready);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (bus_a.mem_ready !== 1'b0 || irq3_a !== 1'b0 || irq7_a !== 1'b0) begin
            errors++; $display("FAIL async_reset: ready %b irq3 %b irq7 %b want 0 0 0", bus_a.mem_ready, irq3_a, irq7_a);
        end
        bus_a.mem_valid = 1'b0; bus_a.mem_wstrb = 4'h0;
        @(negedge clk); rst = 1'b0;
        bus_xfer(0, 32'h0200_0000, 4'h0, 32'h0, rd, flt, rdy, n);
        vectors++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL msip_after_reset: got %h want 0", rd);
        end
        bus_xfer(0, 32'h0200_4000, 4'h0, 32'h0, rd, flt, rdy, n);
        vectors++;
        if (rd !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL cmp_after_reset: got %h want ffffffff", rd);
        end
        bus_xfer(0, 32'h0200_BFF8, 4'h0, 32'h0, rd, flt, rdy, n);
        vectors++;
        if (rd !== 32'(n - 1)) begin
            errors++; $display("FAIL mtime_after_reset: got %h want %h", rd, 32'(n - 1));
        end
    endtask

    initial begin
        bus_a.mem_valid = 1'b0; bus_a.mem_addr = 32'h0; bus_a.mem_wstrb = 4'h0; bus_a.mem_wdata = 32'h0;
        bus_b.mem_valid = 1'b0; bus_b.mem_addr = 32'h0; bus_b.mem_wstrb = 4'h0; bus_b.mem_wdata = 32'h0;
        test_reset();
        test_prescaler();
        test_mtime_write();
        test_mtip();
        test_msip();
        test_fault();
        test_reset_in_ack();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

endmodule
